// File: rtl/mpmc10_wr_strip_seq.sv
// Write-burst strip sequencer for the mpmc10 MIG application port.
// Each strip is one data beat followed by one write command; address and strip index step per strip.
module mpmc10_wr_strip_seq #(
  parameter int         AMSB        = 31,
  parameter int         STRIP_BYTES = 16,
  parameter logic [2:0] CMD_WRITE   = 3'b000
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic [AMSB:0] i_base_adr,
  input  logic [5:0]    i_num_strips,
  input  logic          i_app_rdy,
  input  logic          i_app_wdf_rdy,
  output logic          o_app_en,
  output logic [2:0]    o_app_cmd,
  output logic [AMSB:0] o_app_addr,
  output logic          o_app_wdf_wren,
  output logic          o_app_wdf_end,
  output logic [5:0]    o_data_strip,
  output logic          o_busy,
  output logic          o_done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WDATA = 3'd1,
    S_WCMD  = 3'd2,
    S_NEXT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [AMSB:0] LP_STEP = (AMSB+1)'(STRIP_BYTES);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [5:0]    r_last;
  logic [AMSB:0] r_app_addr;
  logic [5:0]    r_data_strip;
  logic          r_app_en;
  logic [2:0]    r_app_cmd;
  logic          r_wren;
  logic          r_busy;
  logic          r_done;

  logic [5:0]    w_last;
  logic [AMSB:0] w_app_addr;
  logic [5:0]    w_data_strip;
  logic          w_app_en;
  logic          w_wren;
  logic          w_busy;
  logic          w_done;

  // State and all outputs are registered; outputs follow the state being entered.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_last       <= 6'd0;
      r_app_addr   <= '0;
      r_data_strip <= 6'd0;
      r_app_en     <= 1'b0;
      r_app_cmd    <= CMD_WRITE;
      r_wren       <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_last       <= w_last;
      r_app_addr   <= w_app_addr;
      r_data_strip <= w_data_strip;
      r_app_en     <= w_app_en;
      r_app_cmd    <= CMD_WRITE;
      r_wren       <= w_wren;
      r_busy       <= w_busy;
      r_done       <= w_done;
    end
  end

  // Next-state: each valid is held until its ready is seen.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_state_nxt = S_WDATA;
        else         w_state_nxt = S_IDLE;
      end
      S_WDATA: begin
        if (i_app_wdf_rdy) w_state_nxt = S_WCMD;
        else               w_state_nxt = S_WDATA;
      end
      S_WCMD: begin
        if (i_app_rdy) w_state_nxt = S_NEXT;
        else           w_state_nxt = S_WCMD;
      end
      S_NEXT: begin
        if (r_data_strip == r_last) w_state_nxt = S_DONE;
        else                        w_state_nxt = S_WDATA;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output values for the next cycle; address/strip move only in IDLE capture or NEXT.
  always_comb begin
    w_last       = r_last;
    w_app_addr   = r_app_addr;
    w_data_strip = r_data_strip;
    w_wren       = (w_state_nxt == S_WDATA);
    w_app_en     = (w_state_nxt == S_WCMD);
    w_busy       = (w_state_nxt == S_WDATA) || (w_state_nxt == S_WCMD) || (w_state_nxt == S_NEXT);
    w_done       = (w_state_nxt == S_DONE);
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_last       = i_num_strips;
          w_app_addr   = i_base_adr;
          w_data_strip = 6'd0;
        end else begin
          w_last       = r_last;
        end
      end
      S_NEXT: begin
        if (r_data_strip != r_last) begin
          w_data_strip = r_data_strip + 6'd1;
          w_app_addr   = r_app_addr + LP_STEP;
        end else begin
          w_data_strip = r_data_strip;
        end
      end
      default: begin
        w_last = r_last;
      end
    endcase
  end

  assign o_app_en       = r_app_en;
  assign o_app_cmd      = r_app_cmd;
  assign o_app_addr     = r_app_addr;
  assign o_app_wdf_wren = r_wren;
  assign o_app_wdf_end  = r_wren;
  assign o_data_strip   = r_data_strip;
  assign o_busy         = r_busy;
  assign o_done         = r_done;

endmodule

// File: tb/tb_mpmc10_wr_strip_seq.sv
// Bench for mpmc10_wr_strip_seq: table of bursts with per-strip backpressure,
// beat/command scoreboard queues, plus hand-written reset sequences.
module tb_mpmc10_wr_strip_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base_adr;
  logic [5:0]  num_strips;
  logic        app_rdy;
  logic        app_wdf_rdy;
  logic        app_en;
  logic [2:0]  app_cmd;
  logic [31:0] app_addr;
  logic        app_wdf_wren;
  logic        app_wdf_end;
  logic [5:0]  data_strip;
  logic        busy;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mpmc10_wr_strip_seq #(.AMSB(31), .STRIP_BYTES(16), .CMD_WRITE(3'b000)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_base_adr(base_adr),
    .i_num_strips(num_strips), .i_app_rdy(app_rdy), .i_app_wdf_rdy(app_wdf_rdy),
    .o_app_en(app_en), .o_app_cmd(app_cmd), .o_app_addr(app_addr),
    .o_app_wdf_wren(app_wdf_wren), .o_app_wdf_end(app_wdf_end),
    .o_data_strip(data_strip), .o_busy(busy), .o_done(done)
  );

  typedef struct {
    logic [31:0] base;
    logic [5:0]  num;
    int          wstall_strip;
    int          wstall_n;
    int          cstall_strip;
    int          cstall_n;
    int          inj_k;
    int          exp_done;
  } vec_t;

  typedef struct {
    logic [5:0]  strip;
    logic [31:0] addr;
  } exp_t;

  vec_t vecs[6];
  exp_t beat_q[$];
  exp_t cmd_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " app_en"}, {63'd0, app_en}, 64'd0);
    chk({tag, " app_cmd"}, {61'd0, app_cmd}, 64'd0);
    chk({tag, " app_addr"}, {32'd0, app_addr}, 64'd0);
    chk({tag, " wren"}, {63'd0, app_wdf_wren}, 64'd0);
    chk({tag, " wend"}, {63'd0, app_wdf_end}, 64'd0);
    chk({tag, " data_strip"}, {58'd0, data_strip}, 64'd0);
    chk({tag, " busy"}, {63'd0, busy}, 64'd0);
    chk({tag, " done"}, {63'd0, done}, 64'd0);
  endtask

  task automatic run_vec(input int vi);
    vec_t  v;
    exp_t  e;
    exp_t  got;
    int    wleft;
    int    cleft;
    bit    wpend;
    bit    cpend;
    bit    done_seen;
    logic [31:0] paddr;
    logic [5:0]  pstrip;
    v = vecs[vi];
    wleft = v.wstall_n;
    cleft = v.cstall_n;
    wpend = 1'b0;
    cpend = 1'b0;
    done_seen = 1'b0;
    paddr = 32'd0;
    pstrip = 6'd0;
    beat_q.delete();
    cmd_q.delete();
    @(negedge clk);
    start = 1'b1;
    base_adr = v.base;
    num_strips = v.num;
    app_wdf_rdy = 1'b1;
    app_rdy = 1'b1;
    for (int i = 0; i <= int'(v.num); i++) begin
      e.strip = 6'(i);
      e.addr = v.base + 32'(16 * i);
      beat_q.push_back(e);
      cmd_q.push_back(e);
    end
    for (int k = 1; k < 400; k++) begin
      @(negedge clk);
      start = (k == v.inj_k);
      if (k == v.inj_k) begin
        base_adr = 32'hDEAD0000;
        num_strips = 6'd7;
      end
      if (k == 1) begin
        chk($sformatf("v%0d first wren", vi), {63'd0, app_wdf_wren}, 64'd1);
        chk($sformatf("v%0d first addr", vi), {32'd0, app_addr}, {32'd0, v.base});
      end
      chk($sformatf("v%0d wend==wren k%0d", vi, k), {63'd0, app_wdf_end}, {63'd0, app_wdf_wren});
      if (wpend || cpend) begin
        if (wpend) chk($sformatf("v%0d wren held k%0d", vi, k), {63'd0, app_wdf_wren}, 64'd1);
        else       chk($sformatf("v%0d en held k%0d", vi, k), {63'd0, app_en}, 64'd1);
        chk($sformatf("v%0d stall addr k%0d", vi, k), {32'd0, app_addr}, {32'd0, paddr});
        chk($sformatf("v%0d stall strip k%0d", vi, k), {58'd0, data_strip}, {58'd0, pstrip});
      end
      if (app_wdf_wren && int'(data_strip) == v.wstall_strip && wleft > 0) begin
        app_wdf_rdy = 1'b0;
        wleft--;
      end else begin
        app_wdf_rdy = 1'b1;
      end
      if (app_en && int'(data_strip) == v.cstall_strip && cleft > 0) begin
        app_rdy = 1'b0;
        cleft--;
      end else begin
        app_rdy = 1'b1;
      end
      if (app_wdf_wren && app_wdf_rdy) begin
        if (beat_q.size() == 0) begin
          chk($sformatf("v%0d extra beat k%0d", vi, k), 64'd1, 64'd0);
        end else begin
          got = beat_q.pop_front();
          chk($sformatf("v%0d beat strip", vi), {58'd0, data_strip}, {58'd0, got.strip});
          chk($sformatf("v%0d beat addr", vi), {32'd0, app_addr}, {32'd0, got.addr});
        end
      end
      if (app_en && app_rdy) begin
        if (cmd_q.size() == 0) begin
          chk($sformatf("v%0d extra cmd k%0d", vi, k), 64'd1, 64'd0);
        end else begin
          got = cmd_q.pop_front();
          chk($sformatf("v%0d cmd addr", vi), {32'd0, app_addr}, {32'd0, got.addr});
          chk($sformatf("v%0d cmd strip", vi), {58'd0, data_strip}, {58'd0, got.strip});
          chk($sformatf("v%0d cmd code", vi), {61'd0, app_cmd}, 64'd0);
        end
      end
      wpend = app_wdf_wren && !app_wdf_rdy;
      cpend = app_en && !app_rdy;
      paddr = app_addr;
      pstrip = data_strip;
      if (done) begin
        chk($sformatf("v%0d done cycle", vi), 64'(k), 64'(v.exp_done));
        chk($sformatf("v%0d busy at done", vi), {63'd0, busy}, 64'd0);
        chk($sformatf("v%0d beats left", vi), 64'(beat_q.size()), 64'd0);
        chk($sformatf("v%0d cmds left", vi), 64'(cmd_q.size()), 64'd0);
        done_seen = 1'b1;
        break;
      end else begin
        chk($sformatf("v%0d busy k%0d", vi, k), {63'd0, busy}, 64'd1);
      end
    end
    start = 1'b0;
    if (!done_seen) begin
      chk($sformatf("v%0d done timeout", vi), 64'd0, 64'd1);
    end
    @(negedge clk);
    chk($sformatf("v%0d done one cycle", vi), {63'd0, done}, 64'd0);
    chk($sformatf("v%0d busy after", vi), {63'd0, busy}, 64'd0);
  endtask

  initial begin
    // base, num, wdf-stall strip/cycles, cmd-stall strip/cycles, inject-start cycle, done cycle
    vecs[0] = '{32'h0000_1000, 6'd0,  -1, 0, -1, 0, -1, 4};
    vecs[1] = '{32'h0000_2000, 6'd3,  -1, 0, -1, 0, -1, 13};
    vecs[2] = '{32'h0000_3000, 6'd3,   1, 5,  2, 3, -1, 21};
    vecs[3] = '{32'hFFFF_FFF0, 6'd1,  -1, 0, -1, 0, -1, 7};
    vecs[4] = '{32'h0000_5000, 6'd2,  -1, 0, -1, 0,  4, 10};
    vecs[5] = '{32'h0000_0040, 6'd63,  0, 2,  0, 1, -1, 196};

    rst = 1'b1;
    start = 1'b0;
    base_adr = 32'd0;
    num_strips = 6'd0;
    app_rdy = 1'b1;
    app_wdf_rdy = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Reset during WCMD of strip 2, then confirm a clean idle
    @(negedge clk);
    start = 1'b1;
    base_adr = 32'h0000_6000;
    num_strips = 6'd3;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("midrst en before", {63'd0, app_en}, 64'd1);
    chk("midrst addr before", {32'd0, app_addr}, 64'h6020);
    chk("midrst strip before", {58'd0, data_strip}, 64'd2);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("midrst");
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("midrst no done %0d", k), {63'd0, done}, 64'd0);
      chk($sformatf("midrst idle busy %0d", k), {63'd0, busy}, 64'd0);
    end

    for (int vi = 0; vi < 6; vi++) begin
      run_vec(vi);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
